// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - classifies a debounced button level into press/release/short/long/double/repeat events
// Optional auto-repeat while long-held: define BUTTON_AUTOREPEAT_EN.
module button_event_decoder #(
  parameter int COUNTER_WIDTH = 24
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_debounced_signal,
  input  logic [COUNTER_WIDTH-1:0] i_long_cycles,
  input  logic [COUNTER_WIDTH-1:0] i_double_cycles,
  input  logic [COUNTER_WIDTH-1:0] i_repeat_cycles,
  output logic                     o_press_pulse,
  output logic                     o_release_pulse,
  output logic                     o_short_press,
  output logic                     o_long_press,
  output logic                     o_double_click,
  output logic                     o_long_held,
  output logic                     o_repeat_pulse
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG_HELD,
    ST_WAIT_GAP,
    ST_SECOND_HELD
  } state_t;

  state_t                   state;
  logic                     sig_q;
  logic                     sig_prev;
  logic                     rise;
  logic                     fall;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic                     cnt_sat;

  // History resets low so a level already high at reset release reads as a press.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sig_q    <= 1'b0;
      sig_prev <= 1'b0;
    end else begin
      sig_q    <= i_debounced_signal;
      sig_prev <= sig_q;
    end
  end

  assign rise    = sig_q & ~sig_prev;
  assign fall    = ~sig_q & sig_prev;
  assign cnt_sat = &cnt;

  // Edges are tested before thresholds so a coincident edge always wins.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
      o_short_press   <= 1'b0;
      o_long_press    <= 1'b0;
      o_double_click  <= 1'b0;
      o_long_held     <= 1'b0;
    end else begin
      o_press_pulse   <= rise;
      o_release_pulse <= fall;
      o_short_press   <= 1'b0;
      o_long_press    <= 1'b0;
      o_double_click  <= 1'b0;
      cnt             <= cnt_sat ? cnt : cnt + CNT_ONE;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state <= ST_PRESSED;
            cnt   <= '0;
          end
        end
        ST_PRESSED: begin
          if (fall) begin
            state <= ST_WAIT_GAP;
            cnt   <= '0;
          end else if (cnt >= i_long_cycles) begin
            o_long_press <= 1'b1;
            o_long_held  <= 1'b1;
            state        <= ST_LONG_HELD;
            cnt          <= '0;
          end
        end
        ST_LONG_HELD: begin
          if (fall) begin
            o_long_held <= 1'b0;
            state       <= ST_IDLE;
            cnt         <= '0;
          end
        end
        ST_WAIT_GAP: begin
          if (rise) begin
            o_double_click <= 1'b1;
            state          <= ST_SECOND_HELD;
            cnt            <= '0;
          end else if (cnt >= i_double_cycles) begin
            o_short_press <= 1'b1;
            state         <= ST_IDLE;
            cnt           <= '0;
          end
        end
        ST_SECOND_HELD: begin
          if (fall) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          o_long_held <= 1'b0;
          state       <= ST_IDLE;
          cnt         <= '0;
        end
      endcase
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  logic [COUNTER_WIDTH-1:0] rcnt;
  logic                     rcnt_sat;

  assign rcnt_sat = &rcnt;

  // rcnt idles at zero outside LONG_HELD, so entry starts a fresh period.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rcnt           <= '0;
      o_repeat_pulse <= 1'b0;
    end else if (state == ST_LONG_HELD && !fall) begin
      if (rcnt >= i_repeat_cycles) begin
        o_repeat_pulse <= 1'b1;
        rcnt           <= '0;
      end else begin
        o_repeat_pulse <= 1'b0;
        rcnt           <= rcnt_sat ? rcnt : rcnt + CNT_ONE;
      end
    end else begin
      o_repeat_pulse <= 1'b0;
      rcnt           <= '0;
    end
  end
`else
  logic unused_repeat_cycles;

  assign unused_repeat_cycles = ^i_repeat_cycles;
  assign o_repeat_pulse       = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - scoreboard bench for button_event_decoder
module tb_button_event_decoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0;
  logic [W-1:0] long_cyc = 8'd20;
  logic [W-1:0] dbl_cyc = 8'd10;
  logic [W-1:0] rep_cyc = 8'd4;
  logic         press_p, release_p, short_p, long_p, double_p, long_held, repeat_p;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int c;
    int kind;
  } exp_t;
  exp_t exp_q[$];

  button_event_decoder #(.COUNTER_WIDTH(W)) dut (
    .i_clock           (clk),
    .i_reset_n         (rst_n),
    .i_debounced_signal(din),
    .i_long_cycles     (long_cyc),
    .i_double_cycles   (dbl_cyc),
    .i_repeat_cycles   (rep_cyc),
    .o_press_pulse     (press_p),
    .o_release_pulse   (release_p),
    .o_short_press     (short_p),
    .o_long_press      (long_p),
    .o_double_click    (double_p),
    .o_long_held       (long_held),
    .o_repeat_pulse    (repeat_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Kinds: 0 press, 1 release, 2 short, 3 long, 4 double, 5 repeat; kept sorted by (cycle, kind).
  task automatic push_exp(input int c, input int kind);
    exp_t e;
    int   i;
    e.c = c;
    e.kind = kind;
    i = 0;
    while (i < exp_q.size() && (exp_q[i].c < c || (exp_q[i].c == c && exp_q[i].kind <= kind))) i++;
    exp_q.insert(i, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [5:0] p;
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
      chk("missed_pulse", -1, exp_q[0].kind);
      void'(exp_q.pop_front());
    end
    p = {repeat_p, double_p, long_p, short_p, release_p, press_p};
    for (int k = 0; k < 6; k++) begin
      if (p[k]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", k, -1);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", k, e.kind);
          chk("pulse_cycle", cyc, e.c);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, u;
    // Reset held with input toggling: nothing may come out.
    for (int i = 0; i < 6; i++) begin
      tick(1);
      din = ~din;
      chk("reset_outs", int'({press_p, release_p, short_p, long_p, double_p, long_held, repeat_p}), 0);
    end
    din = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("post_reset_quiet", exp_q.size(), 0);

    // Short press.
    t0 = cyc;
    din = 1'b1;
    push_exp(t0 + 2, 0);
    tick(5);
    t1 = cyc;
    din = 1'b0;
    push_exp(t1 + 2, 1);
    push_exp(t1 + 13, 2);
    tick(30);
    chk("short_drain", exp_q.size(), 0);

    // Long press with optional auto-repeat.
    t0 = cyc;
    din = 1'b1;
    push_exp(t0 + 2, 0);
    push_exp(t0 + 23, 3);
`ifdef BUTTON_AUTOREPEAT_EN
    for (int p = t0 + 28; p < t0 + 42; p += 5) push_exp(p, 5);
`endif
    tick(22);
    chk("held_before_long", int'(long_held), 0);
    tick(1);
    chk("held_at_long", int'(long_held), 1);
    tick(17);
    din = 1'b0;
    push_exp(t0 + 42, 1);
    chk("held_mid", int'(long_held), 1);
    tick(1);
    chk("held_before_release", int'(long_held), 1);
    tick(1);
    chk("held_after_release", int'(long_held), 0);
    tick(30);
    chk("long_drain", exp_q.size(), 0);

    // Double click.
    t0 = cyc;
    din = 1'b1;
    push_exp(t0 + 2, 0);
    tick(3);
    din = 1'b0;
    push_exp(t0 + 5, 1);
    tick(4);
    din = 1'b1;
    push_exp(t0 + 9, 0);
    push_exp(t0 + 9, 4);
    tick(3);
    din = 1'b0;
    push_exp(t0 + 12, 1);
    tick(30);
    chk("double_drain", exp_q.size(), 0);

    // Rise lands on the same cycle the gap threshold is reached: double wins.
    t0 = cyc;
    din = 1'b1;
    push_exp(t0 + 2, 0);
    tick(3);
    t1 = cyc;
    din = 1'b0;
    push_exp(t1 + 2, 1);
    tick(11);
    din = 1'b1;
    push_exp(t1 + 13, 0);
    push_exp(t1 + 13, 4);
    tick(4);
    din = 1'b0;
    push_exp(t1 + 17, 1);
    tick(30);
    chk("boundary_drain", exp_q.size(), 0);

    // Long threshold of zero fires on the first PRESSED cycle.
    long_cyc = 8'd0;
    tick(1);
    t0 = cyc;
    din = 1'b1;
    push_exp(t0 + 2, 0);
    push_exp(t0 + 3, 3);
`ifdef BUTTON_AUTOREPEAT_EN
    push_exp(t0 + 8, 5);
    push_exp(t0 + 13, 5);
`endif
    tick(12);
    din = 1'b0;
    push_exp(t0 + 14, 1);
    tick(20);
    chk("long0_drain", exp_q.size(), 0);
    long_cyc = 8'd20;

    // Reset mid-press aborts silently; input high at release reads as a new press.
    t0 = cyc;
    din = 1'b1;
    push_exp(t0 + 2, 0);
    tick(10);
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", int'({press_p, release_p, short_p, long_p, double_p, long_held, repeat_p}), 0);
    tick(3);
    u = cyc;
    rst_n = 1'b1;
    push_exp(u + 2, 0);
    tick(5);
    t1 = cyc;
    din = 1'b0;
    push_exp(t1 + 2, 1);
    push_exp(t1 + 13, 2);
    tick(30);
    chk("final_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
